registers: RTL and testbench



---
 rtl/registers.sv | 82 ++++++++
 tb/tb_registers.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/registers.sv
// Input-side storage for the 2-D convolver: kernel weight register plus a
// raster-scan line buffer that presents a KERNEL_SIZE x KERNEL_SIZE pixel
// window. The whole buffer is one shift chain. Window rows and the inter-row
// remainders are views onto fixed positions of that chain.
module registers #(
    parameter int DATA_WIDTH  = 16,
    parameter int FRAC_BIT    = 8,
    parameter int KERNEL_SIZE = 5,
    parameter int IMAGE_SIZE  = 28
) (
    input  logic                                              clk,
    input  logic                                              reset,
    input  logic                                              write,
    input  logic signed [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] weights,
    input  logic signed [DATA_WIDTH-1:0]                      pixel_input,
    output logic signed [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] weights_out,
    output logic signed [KERNEL_SIZE*DATA_WIDTH-1:0]          data_out_0,
    output logic signed [KERNEL_SIZE*DATA_WIDTH-1:0]          data_out_1,
    output logic signed [KERNEL_SIZE*DATA_WIDTH-1:0]          data_out_2,
    output logic signed [KERNEL_SIZE*DATA_WIDTH-1:0]          data_out_3,
    output logic signed [KERNEL_SIZE*DATA_WIDTH-1:0]          data_out_4,
    output logic signed [(IMAGE_SIZE-KERNEL_SIZE)*DATA_WIDTH-1:0] data_hold_0,
    output logic signed [(IMAGE_SIZE-KERNEL_SIZE)*DATA_WIDTH-1:0] data_hold_1,
    output logic signed [(IMAGE_SIZE-KERNEL_SIZE)*DATA_WIDTH-1:0] data_hold_2,
    output logic signed [(IMAGE_SIZE-KERNEL_SIZE)*DATA_WIDTH-1:0] data_hold_3
);

    localparam int HOLD_LEN  = IMAGE_SIZE - KERNEL_SIZE;
    localparam int CHAIN_LEN = (KERNEL_SIZE - 1) * IMAGE_SIZE + KERNEL_SIZE;

    // The port list hard-wires five window rows; FRAC_BIT only documents the
    // Q format of the samples and must fit inside a sample.
    if (IMAGE_SIZE <= KERNEL_SIZE || KERNEL_SIZE != 5 || FRAC_BIT >= DATA_WIDTH) begin : g_param_check
        $error("registers: unsupported parameter combination");
    end

    // Chain index 0 is the newest pixel (data_out_4[0]); index n holds the
    // pixel written n writes ago. Row r starts at (4-r)*IMAGE_SIZE, and the
    // hold segment of a row follows its KERNEL_SIZE window elements.
    logic signed [DATA_WIDTH-1:0] chain_q [CHAIN_LEN];
    logic signed [DATA_WIDTH-1:0] chain_d [CHAIN_LEN];
    logic signed [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] weights_q;

    // Next chain contents: new pixel at the head, everything else moves one step.
    always_comb begin
        chain_d[0] = pixel_input;
        for (int n = 1; n < CHAIN_LEN; n++) begin
            chain_d[n] = chain_q[n-1];
        end
    end

    // Chain and weight registers; reset clears everything and overrides write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int n = 0; n < CHAIN_LEN; n++) begin
                chain_q[n] <= '0;
            end
            weights_q <= '0;
        end else if (write) begin
            chain_q   <= chain_d;
            weights_q <= weights;
        end
    end

    assign weights_out = weights_q;

    for (genvar e = 0; e < KERNEL_SIZE; e++) begin : g_window
        assign data_out_4[e*DATA_WIDTH +: DATA_WIDTH] = chain_q[0*IMAGE_SIZE + e];
        assign data_out_3[e*DATA_WIDTH +: DATA_WIDTH] = chain_q[1*IMAGE_SIZE + e];
        assign data_out_2[e*DATA_WIDTH +: DATA_WIDTH] = chain_q[2*IMAGE_SIZE + e];
        assign data_out_1[e*DATA_WIDTH +: DATA_WIDTH] = chain_q[3*IMAGE_SIZE + e];
        assign data_out_0[e*DATA_WIDTH +: DATA_WIDTH] = chain_q[4*IMAGE_SIZE + e];
    end

    for (genvar e = 0; e < HOLD_LEN; e++) begin : g_hold
        assign data_hold_3[e*DATA_WIDTH +: DATA_WIDTH] = chain_q[0*IMAGE_SIZE + KERNEL_SIZE + e];
        assign data_hold_2[e*DATA_WIDTH +: DATA_WIDTH] = chain_q[1*IMAGE_SIZE + KERNEL_SIZE + e];
        assign data_hold_1[e*DATA_WIDTH +: DATA_WIDTH] = chain_q[2*IMAGE_SIZE + KERNEL_SIZE + e];
        assign data_hold_0[e*DATA_WIDTH +: DATA_WIDTH] = chain_q[3*IMAGE_SIZE + KERNEL_SIZE + e];
    end

endmodule

// File: tb/tb_registers.sv
// Bench for the convolver input storage. The reference model is a history of
// accepted pixels (newest first): a port element is expected to hold the pixel
// written a fixed number of writes ago, or 0 if fewer writes have happened.
module tb_registers;

    localparam int DW   = 16;
    localparam int K    = 5;
    localparam int I    = 28;
    localparam int NW   = K * K;
    localparam int CLEN = (K - 1) * I + K;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 write;
    logic [NW*DW-1:0]     weights;
    logic [DW-1:0]        pixel_input;
    logic [NW*DW-1:0]     weights_out;
    logic [K*DW-1:0]      data_out_0, data_out_1, data_out_2, data_out_3, data_out_4;
    logic [(I-K)*DW-1:0]  data_hold_0, data_hold_1, data_hold_2, data_hold_3;

    int n_vec = 0;
    int n_err = 0;

    logic [DW-1:0]    hist [$];
    logic [NW*DW-1:0] wexp;

    registers #(.DATA_WIDTH(DW), .FRAC_BIT(8), .KERNEL_SIZE(K), .IMAGE_SIZE(I)) dut (
        .clk(clk), .reset(reset), .write(write), .weights(weights),
        .pixel_input(pixel_input), .weights_out(weights_out),
        .data_out_0(data_out_0), .data_out_1(data_out_1), .data_out_2(data_out_2),
        .data_out_3(data_out_3), .data_out_4(data_out_4),
        .data_hold_0(data_hold_0), .data_hold_1(data_hold_1),
        .data_hold_2(data_hold_2), .data_hold_3(data_hold_3)
    );

    always #5 clk = ~clk;

    // Pixel written n writes ago, or 0 if the chain has not been filled that far.
    function automatic logic [DW-1:0] exp_at(input int n);
        if (n < hist.size()) return hist[n];
        return '0;
    endfunction

    // Element k of the repeating 0x0100..0x0900 stream.
    function automatic logic [DW-1:0] seqpix(input int k);
        return DW'(((k % 9) + 1) * 256);
    endfunction

    task automatic check(input string tag, input int idx, input logic [DW-1:0] got, input logic [DW-1:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s[%0d]: got %h, expected %h", tag, idx, got, want);
        end
    endtask

    task automatic check_all();
        for (int e = 0; e < K; e++) begin
            check("out4", e, data_out_4[e*DW +: DW], exp_at(0*I + e));
            check("out3", e, data_out_3[e*DW +: DW], exp_at(1*I + e));
            check("out2", e, data_out_2[e*DW +: DW], exp_at(2*I + e));
            check("out1", e, data_out_1[e*DW +: DW], exp_at(3*I + e));
            check("out0", e, data_out_0[e*DW +: DW], exp_at(4*I + e));
        end
        for (int e = 0; e < I - K; e++) begin
            check("hold3", e, data_hold_3[e*DW +: DW], exp_at(0*I + K + e));
            check("hold2", e, data_hold_2[e*DW +: DW], exp_at(1*I + K + e));
            check("hold1", e, data_hold_1[e*DW +: DW], exp_at(2*I + K + e));
            check("hold0", e, data_hold_0[e*DW +: DW], exp_at(3*I + K + e));
        end
        for (int k = 0; k < NW; k++) begin
            check("wts", k, weights_out[k*DW +: DW], wexp[k*DW +: DW]);
        end
    endtask

    // One clock: drive, update the model at the edge, check just after it.
    task automatic step(input logic w, input logic [DW-1:0] px);
        write       = w;
        pixel_input = px;
        @(posedge clk);
        if (reset) begin
            hist.delete();
            wexp = '0;
        end else if (w) begin
            hist.push_front(px);
            if (hist.size() > CLEN) void'(hist.pop_back());
            wexp = weights;
        end
        #1;
        check_all();
    endtask

    task automatic set_weights(input logic [DW-1:0] v);
        for (int k = 0; k < NW; k++) weights[k*DW +: DW] = v;
    endtask

    task automatic random_weights();
        for (int k = 0; k < NW; k++) weights[k*DW +: DW] = DW'($urandom);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seq;
        logic [DW-1:0] ones;

        // Reset held with write active: everything stays 0, reset wins.
        reset       = 1'b1;
        write       = 1'b1;
        pixel_input = 16'h0100;
        hist.delete();
        wexp = '0;
        random_weights();
        #1;
        check_all();
        repeat (5) step(1'b1, 16'h0100);

        // Released but no writes: nothing moves.
        reset = 1'b0;
        for (int i = 0; i < 10; i++) step(1'b0, (i % 2 == 0) ? 16'hAAAA : 16'h5555);

        // Fill the first window row.
        seq = 0;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, seqpix(seq));
            seq++;
        end
        for (int e = 0; e < K; e++) check("fill_out4", e, data_out_4[e*DW +: DW], DW'((5 - e) * 256));
        check("fill_hold3", 0, data_hold_3[0 +: DW], 16'h0000);

        // Stream the repeating sequence, with a three-clock stall mid-stream.
        while (seq < 140) begin
            step(1'b1, seqpix(seq));
            seq++;
            if (seq == 6)   check("first_hold3", 0, data_hold_3[0 +: DW], 16'h0100);
            if (seq == 29)  check("first_out3", 0, data_out_3[0 +: DW], 16'h0100);
            if (seq == 117) check("first_out0", 4, data_out_0[4*DW +: DW], 16'h0100);
            if (seq == 60) begin
                for (int s = 0; s < 3; s++) step(1'b0, DW'($urandom));
            end
        end

        // Randomized writes, pixels and weights.
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(7) == 0) random_weights();
            step($urandom_range(3) != 0, DW'($urandom));
        end

        // Weight load, hold and reload.
        ones = 16'h0100;
        set_weights(ones);
        step(1'b1, DW'($urandom));
        for (int k = 0; k < NW; k++) check("w_load", k, weights_out[k*DW +: DW], 16'h0100);
        set_weights(16'hFF00);
        step(1'b0, DW'($urandom));
        for (int k = 0; k < NW; k++) check("w_hold", k, weights_out[k*DW +: DW], 16'h0100);
        step(1'b1, DW'($urandom));
        for (int k = 0; k < NW; k++) check("w_reload", k, weights_out[k*DW +: DW], 16'hFF00);

        // Asynchronous reset between edges clears at once, then refill.
        for (int i = 0; i < 10; i++) step(1'b1, DW'($urandom));
        #2;
        reset = 1'b1;
        #1;
        hist.delete();
        wexp = '0;
        check_all();
        check("async_out0", 4, data_out_0[4*DW +: DW], 16'h0000);
        step(1'b1, 16'h0700);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) step(1'b1, DW'($urandom));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
